hazard_ctl: RTL and testbench
=============================

Name: hazard_ctl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Detects load-use hazards between ID and EX.
- Squashes wrong-path instructions on a taken branch or jump resolved in EX.
- Freezes the front of the pipeline for multi-cycle multiply/divide held in EX.
- Drives the PC, IF/ID, ID/EX and EX/MEM hold/flush controls; ex_hold feeds the ID/EX register's EX_Bubble input.

Parameters:
MUL_LAT, 4, multiply occupancy in EX in cycles (>=1)
DIV_LAT, 32, divide occupancy in EX in cycles (>=1)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_dst  in  5  destination register of the instruction in EX
ex_rfwr  in  1  EX instruction writes the register file
ex_dmrd  in  1  EX instruction is a load
ex_br_taken  in  1  branch in EX resolved taken
ex_jump  in  1  jump in EX
ex_md_start  in  1  EX instruction is MULT/DIV
ex_md_div  in  1  qualifies ex_md_start: 1=divide, 0=multiply
cnt_clr  in  1  synchronous clear of the performance counters
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  zero IF/ID (insert nop)
idex_flush  out  1  load nop into ID/EX
ex_hold  out  1  hold ID/EX contents (EX_Bubble)
exmem_bubble  out  1  load nop into EX/MEM
md_busy  out  1  multi-cycle op occupying EX
md_done  out  1  one-cycle pulse: MD op leaves EX this cycle
stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1
flush_cnt  out  CNT_W  saturating count of cycles with ifid_flush=1

Behaviour:
State and reset:
- States: RUN, MD_BUSY. Counter md_cnt is 6 bits, so MUL_LAT and DIV_LAT are <=64.
- rst=1 at a clock edge: state=RUN, md_cnt=0, stall_cycles=0, flush_cnt=0.
- While rst=1 all single-bit outputs are forced to 0.

Control outputs:
- Combinational from state, md_cnt and inputs; they take effect in the same cycle.
- Default value 0.

RUN, priority highest first:
1. Flush (ex_br_taken | ex_jump): ifid_flush=1, idex_flush=1, no stall; ex_md_start and load-use are ignored this cycle.
2. MD entry (ex_md_start): pc_stall=ifid_stall=ex_hold=exmem_bubble=md_busy=1; next state MD_BUSY; md_cnt loaded with (ex_md_div ? DIV_LAT : MUL_LAT)-1.
3. Load-use: ex_dmrd & ex_rfwr & ex_dst!=0 & ((id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)). Outputs: pc_stall=ifid_stall=idex_flush=1, exactly 1 cycle per occurrence; the load advances, so the condition clears next cycle.

MD_BUSY:
- md_cnt!=0: pc_stall=ifid_stall=ex_hold=exmem_bubble=md_busy=1; md_cnt decrements.
- md_cnt==0: md_done=1, md_busy=0, no stall, next state RUN.
- The done cycle must not re-trigger MD entry even though ex_md_start is still high.
- Flush and load-use inputs are ignored for the whole of MD_BUSY.
- Total stall for an MD op is exactly LAT cycles (entry cycle plus LAT-1 busy cycles), followed by one done cycle.

Counters:
- Each rising edge: cnt_clr=1 clears both counters, with priority over increment.
- Otherwise stall_cycles increments if pc_stall=1 and flush_cnt increments if ifid_flush=1.
- Both saturate at all-ones.

Reset mid-operation:
- rst during MD_BUSY returns to RUN with md_cnt=0 at that edge; no md_done pulse is produced.

Test Plan:
- Load-use: EX lw to $8 (ex_dmrd=ex_rfwr=1, ex_dst=8); ID add with id_rs=8, id_uses_rs=1 -> one cycle of pc_stall=ifid_stall=idex_flush=1; stall_cycles=1. Repeat with ex_dst=0 -> no stall.
- Branch vs load-use: ex_br_taken=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_stall=0; flush_cnt=1, stall_cycles unchanged.
- Multiply: ex_md_start=1, ex_md_div=0, MUL_LAT=4 -> pc_stall/ex_hold/exmem_bubble high for 4 consecutive cycles, md_done=1 on cycle 5, then RUN with no re-trigger; stall_cycles=4.
- Divide with reset: ex_md_div=1, DIV_LAT=32 -> 32 stall cycles, then md_done. Second run with rst asserted at stall cycle 10 -> all outputs 0 next cycle, state RUN, no md_done pulse.
- Saturation and clear: force 70000 stall cycles with CNT_W=16 -> stall_cycles=16'hFFFF. Assert cnt_clr in the same cycle as a stall -> counter reads 0 next cycle.
- Flush ignored in MD_BUSY: ex_jump=1 during busy cycle 2 of a multiply -> ifid_flush stays 0, stall continues unchanged.

Source files
------------

// File: rtl/hazard_ctl.sv
// rtl/hazard_ctl.sv - stall/flush sequencer for the 5-stage MIPS pipeline
//
// Purpose:
//   Central hazard controller. It detects load-use hazards between ID and EX,
//   squashes wrong-path instructions when a branch or jump resolves taken in
//   EX, and freezes the front of the pipeline while a multi-cycle
//   multiply/divide occupies EX. It also keeps saturating counters of stall
//   cycles and flush cycles.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   id_rs, id_rt    source register fields of the instruction in ID
//   id_uses_rs/rt   ID instruction actually reads rs / rt
//   ex_dst          destination register of the instruction in EX
//   ex_rfwr         EX instruction writes the register file
//   ex_dmrd         EX instruction is a load
//   ex_br_taken     branch in EX resolved taken
//   ex_jump         jump in EX
//   ex_md_start     EX instruction is MULT/DIV
//   ex_md_div       qualifies ex_md_start: 1=divide, 0=multiply
//   cnt_clr         synchronous clear of both performance counters
//   pc_stall        hold PC
//   ifid_stall      hold IF/ID
//   ifid_flush      zero IF/ID (insert nop)
//   idex_flush      load nop into ID/EX
//   ex_hold         hold ID/EX contents (drives EX_Bubble)
//   exmem_bubble    load nop into EX/MEM
//   md_busy         multi-cycle op occupying EX
//   md_done         one-cycle pulse: MD op leaves EX this cycle
//   stall_cycles    saturating count of cycles with pc_stall=1
//   flush_cnt       saturating count of cycles with ifid_flush=1

module hazard_ctl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [4:0]       ex_dst,
   input  logic             ex_rfwr,
   input  logic             ex_dmrd,
   input  logic             ex_br_taken,
   input  logic             ex_jump,
   input  logic             ex_md_start,
   input  logic             ex_md_div,
   input  logic             cnt_clr,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             ex_hold,
   output logic             exmem_bubble,
   output logic             md_busy,
   output logic             md_done,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } state_t;

   // The entry cycle is itself a stall cycle, so the busy countdown starts
   // at LAT-1; the cycle where md_cnt reaches 0 is the done cycle.
   localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
   localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t     state;
   state_t     state_nxt;
   logic [5:0] md_cnt;
   logic [5:0] md_cnt_nxt;

   logic       rs_hit;
   logic       rt_hit;
   logic       load_use;
   logic       redirect;

   // $0 is hard-wired, so a load "to" $0 never creates a dependency.
   assign rs_hit   = id_uses_rs && (id_rs == ex_dst);
   assign rt_hit   = id_uses_rt && (id_rt == ex_dst);
   assign load_use = ex_dmrd && ex_rfwr && (ex_dst != 5'd0) && (rs_hit || rt_hit);
   assign redirect = ex_br_taken || ex_jump;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RUN;
         md_cnt <= 6'd0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      md_cnt_nxt   = md_cnt;
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      ex_hold      = 1'b0;
      exmem_bubble = 1'b0;
      md_busy      = 1'b0;
      md_done      = 1'b0;

      case (state)
         RUN: begin
            if (redirect) begin
               // Wrong-path instructions in IF and ID are squashed; whatever
               // else the EX instruction asks for belongs to a dead path.
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (ex_md_start) begin
               pc_stall     = 1'b1;
               ifid_stall   = 1'b1;
               ex_hold      = 1'b1;
               exmem_bubble = 1'b1;
               md_busy      = 1'b1;
               state_nxt    = MD_BUSY;
               md_cnt_nxt   = ex_md_div ? DIV_LOAD : MUL_LOAD;
            end else if (load_use) begin
               // The load moves on to MEM while a nop enters EX, so this
               // condition is gone on the next cycle.
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
               idex_flush = 1'b1;
            end
         end

         MD_BUSY: begin
            // Redirects and load-use are not looked at here: the pipeline
            // behind EX is frozen, and the done cycle returns straight to
            // RUN without re-sampling ex_md_start.
            if (md_cnt != 6'd0) begin
               pc_stall     = 1'b1;
               ifid_stall   = 1'b1;
               ex_hold      = 1'b1;
               exmem_bubble = 1'b1;
               md_busy      = 1'b1;
               md_cnt_nxt   = md_cnt - 6'd1;
            end else begin
               md_done   = 1'b1;
               state_nxt = RUN;
            end
         end

         default: begin
            state_nxt  = RUN;
            md_cnt_nxt = 6'd0;
         end
      endcase

      if (rst) begin
         pc_stall     = 1'b0;
         ifid_stall   = 1'b0;
         ifid_flush   = 1'b0;
         idex_flush   = 1'b0;
         ex_hold      = 1'b0;
         exmem_bubble = 1'b0;
         md_busy      = 1'b0;
         md_done      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         stall_cycles <= '0;
      end else if (pc_stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         flush_cnt <= '0;
      end else if (ifid_flush && (flush_cnt != '1)) begin
         flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_hazard_ctl.sv
// tb/tb_hazard_ctl.sv - self-checking bench for hazard_ctl

module tb_hazard_ctl;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 32;
   localparam int CNT_W   = 16;

   // {pc_stall, ifid_stall, ifid_flush, idex_flush, ex_hold, exmem_bubble, md_busy, md_done}
   localparam logic [7:0] V_IDLE  = 8'b0000_0000;
   localparam logic [7:0] V_LU    = 8'b1101_0000;
   localparam logic [7:0] V_FLUSH = 8'b0011_0000;
   localparam logic [7:0] V_MD    = 8'b1100_1110;
   localparam logic [7:0] V_DONE  = 8'b0000_0001;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic [4:0]       ex_dst;
   logic             ex_rfwr;
   logic             ex_dmrd;
   logic             ex_br_taken;
   logic             ex_jump;
   logic             ex_md_start;
   logic             ex_md_div;
   logic             cnt_clr;
   logic             pc_stall;
   logic             ifid_stall;
   logic             ifid_flush;
   logic             idex_flush;
   logic             ex_hold;
   logic             exmem_bubble;
   logic             md_busy;
   logic             md_done;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_cnt;

   logic [7:0] obs;
   logic [7:0] exp_q[$];
   logic [7:0] e;
   int         n_checks = 0;
   int         n_fail   = 0;

   assign obs = {pc_stall, ifid_stall, ifid_flush, idex_flush,
                 ex_hold, exmem_bubble, md_busy, md_done};

   always #5 clk = ~clk;

   hazard_ctl #(
      .MUL_LAT(MUL_LAT),
      .DIV_LAT(DIV_LAT),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .ex_dst      (ex_dst),
      .ex_rfwr     (ex_rfwr),
      .ex_dmrd     (ex_dmrd),
      .ex_br_taken (ex_br_taken),
      .ex_jump     (ex_jump),
      .ex_md_start (ex_md_start),
      .ex_md_div   (ex_md_div),
      .cnt_clr     (cnt_clr),
      .pc_stall    (pc_stall),
      .ifid_stall  (ifid_stall),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .ex_hold     (ex_hold),
      .exmem_bubble(exmem_bubble),
      .md_busy     (md_busy),
      .md_done     (md_done),
      .stall_cycles(stall_cycles),
      .flush_cnt   (flush_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs       = 5'd0;
      id_rt       = 5'd0;
      id_uses_rs  = 1'b0;
      id_uses_rt  = 1'b0;
      ex_dst      = 5'd0;
      ex_rfwr     = 1'b0;
      ex_dmrd     = 1'b0;
      ex_br_taken = 1'b0;
      ex_jump     = 1'b0;
      ex_md_start = 1'b0;
      ex_md_div   = 1'b0;
      cnt_clr     = 1'b0;
   endtask

   // lw $8 in EX, add reading $8 as rs in ID
   task automatic drive_lw8_hit();
      ex_dmrd    = 1'b1;
      ex_rfwr    = 1'b1;
      ex_dst     = 5'd8;
      id_rs      = 5'd8;
      id_uses_rs = 1'b1;
      id_rt      = 5'd3;
      id_uses_rt = 1'b1;
   endtask

   task automatic clear_counters();
      idle();
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      drive_lw8_hit();
      ex_jump     = 1'b1;
      ex_md_start = 1'b1;
      exp_q.push_back(V_IDLE);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL rst_outs: got %b expected %b", obs, e); end
      step();
      n_checks++;
      if (stall_cycles !== '0) begin n_fail++; $display("FAIL rst_stall_cnt: got %h expected 0", stall_cycles); end
      n_checks++;
      if (flush_cnt !== '0) begin n_fail++; $display("FAIL rst_flush_cnt: got %h expected 0", flush_cnt); end
      rst = 1'b0;
      idle();
      exp_q.push_back(V_IDLE);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL run_idle: got %b expected %b", obs, e); end
      step();
   endtask

   task automatic test_load_use();
      clear_counters();
      drive_lw8_hit();
      exp_q.push_back(V_LU);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL lu_rs: got %b expected %b", obs, e); end
      step();
      idle();
      exp_q.push_back(V_IDLE);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL lu_clear: got %b expected %b", obs, e); end
      step();
      n_checks++;
      if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cycles); end
      // load to $0 never stalls
      drive_lw8_hit();
      ex_dst = 5'd0;
      id_rs  = 5'd0;
      exp_q.push_back(V_IDLE);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL lu_r0: got %b expected %b", obs, e); end
      step();
      // match on rt only
      idle();
      ex_dmrd = 1'b1; ex_rfwr = 1'b1; ex_dst = 5'd5;
      id_rs = 5'd1; id_uses_rs = 1'b1; id_rt = 5'd5; id_uses_rt = 1'b1;
      exp_q.push_back(V_LU);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL lu_rt: got %b expected %b", obs, e); end
      step();
      // rs matches but is not read
      idle();
      ex_dmrd = 1'b1; ex_rfwr = 1'b1; ex_dst = 5'd9;
      id_rs = 5'd9; id_uses_rs = 1'b0; id_rt = 5'd2; id_uses_rt = 1'b1;
      exp_q.push_back(V_IDLE);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL lu_unused: got %b expected %b", obs, e); end
      step();
      // non-load producer never stalls
      idle();
      drive_lw8_hit();
      ex_dmrd = 1'b0;
      exp_q.push_back(V_IDLE);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL lu_nonload: got %b expected %b", obs, e); end
      step();
      n_checks++;
      if (stall_cycles !== 16'd2) begin n_fail++; $display("FAIL lu_stall_cnt2: got %0d expected 2", stall_cycles); end
      idle();
   endtask

   task automatic test_branch();
      clear_counters();
      drive_lw8_hit();
      ex_br_taken = 1'b1;
      ex_md_start = 1'b1;
      exp_q.push_back(V_FLUSH);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL br_over_lu: got %b expected %b", obs, e); end
      step();
      n_checks++;
      if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL br_flush_cnt: got %0d expected 1", flush_cnt); end
      n_checks++;
      if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL br_stall_cnt: got %0d expected 0", stall_cycles); end
      idle();
      ex_jump = 1'b1;
      exp_q.push_back(V_FLUSH);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL jump: got %b expected %b", obs, e); end
      step();
      // ex_md_start alongside the branch must not have entered MD_BUSY
      idle();
      exp_q.push_back(V_IDLE);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL br_after: got %b expected %b", obs, e); end
      step();
      n_checks++;
      if (flush_cnt !== 16'd2) begin n_fail++; $display("FAIL br_flush_cnt2: got %0d expected 2", flush_cnt); end
   endtask

   task automatic test_multiply();
      clear_counters();
      ex_md_start = 1'b1;
      ex_md_div   = 1'b0;
      for (int i = 0; i < MUL_LAT; i++) exp_q.push_back(V_MD);
      exp_q.push_back(V_DONE);
      exp_q.push_back(V_IDLE);
      for (int c = 0; c < MUL_LAT + 2; c++) begin
         if (c == MUL_LAT + 1) idle();
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL mul_seq[%0d]: got %b expected %b", c, obs, e); end
         step();
      end
      n_checks++;
      if (stall_cycles !== 16'(MUL_LAT)) begin n_fail++; $display("FAIL mul_stall_cnt: got %0d expected %0d", stall_cycles, MUL_LAT); end
   endtask

   task automatic test_flush_in_md();
      clear_counters();
      ex_md_start = 1'b1;
      for (int i = 0; i < MUL_LAT; i++) exp_q.push_back(V_MD);
      exp_q.push_back(V_DONE);
      exp_q.push_back(V_IDLE);
      for (int c = 0; c < MUL_LAT + 2; c++) begin
         ex_jump     = (c == 2);
         ex_br_taken = (c == MUL_LAT);
         if (c == 2) drive_lw8_hit();
         if (c == MUL_LAT + 1) idle();
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL md_flush_seq[%0d]: got %b expected %b", c, obs, e); end
         step();
      end
      n_checks++;
      if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL md_flush_cnt: got %0d expected 0", flush_cnt); end
      n_checks++;
      if (stall_cycles !== 16'(MUL_LAT)) begin n_fail++; $display("FAIL md_flush_stall_cnt: got %0d expected %0d", stall_cycles, MUL_LAT); end
   endtask

   task automatic test_divide();
      clear_counters();
      ex_md_start = 1'b1;
      ex_md_div   = 1'b1;
      for (int i = 0; i < DIV_LAT; i++) exp_q.push_back(V_MD);
      exp_q.push_back(V_DONE);
      for (int c = 0; c < DIV_LAT + 1; c++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL div_seq[%0d]: got %b expected %b", c, obs, e); end
         step();
      end
      idle();
      n_checks++;
      if (stall_cycles !== 16'(DIV_LAT)) begin n_fail++; $display("FAIL div_stall_cnt: got %0d expected %0d", stall_cycles, DIV_LAT); end
      // second divide, reset at stall cycle 10
      ex_md_start = 1'b1;
      ex_md_div   = 1'b1;
      for (int i = 0; i < 9; i++) exp_q.push_back(V_MD);
      exp_q.push_back(V_IDLE);
      exp_q.push_back(V_IDLE);
      exp_q.push_back(V_LU);
      for (int c = 0; c < 12; c++) begin
         if (c == 9) rst = 1'b1;
         if (c == 10) begin rst = 1'b0; idle(); end
         if (c == 11) drive_lw8_hit();
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL div_rst_seq[%0d]: got %b expected %b", c, obs, e); end
         step();
      end
      idle();
      n_checks++;
      if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL div_rst_stall_cnt: got %0d expected 1", stall_cycles); end
   endtask

   task automatic test_back_to_back();
      clear_counters();
      ex_md_start = 1'b1;
      ex_md_div   = 1'b0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < MUL_LAT; i++) exp_q.push_back(V_MD);
         exp_q.push_back(V_DONE);
      end
      exp_q.push_back(V_IDLE);
      for (int c = 0; c < 2 * (MUL_LAT + 1) + 1; c++) begin
         if (c == 2 * (MUL_LAT + 1)) idle();
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL b2b_seq[%0d]: got %b expected %b", c, obs, e); end
         step();
      end
      n_checks++;
      if (stall_cycles !== 16'(2 * MUL_LAT)) begin n_fail++; $display("FAIL b2b_stall_cnt: got %0d expected %0d", stall_cycles, 2 * MUL_LAT); end
   endtask

   task automatic test_saturation();
      clear_counters();
      drive_lw8_hit();
      exp_q.push_back(V_LU);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL sat_first: got %b expected %b", obs, e); end
      repeat (70000) @(posedge clk);
      #1;
      n_checks++;
      if (stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_stall: got %h expected ffff", stall_cycles); end
      cnt_clr = 1'b1;
      step();
      idle();
      n_checks++;
      if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL clr_over_inc: got %h expected 0", stall_cycles); end
      n_checks++;
      if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL sat_flush_cnt: got %h expected 0", flush_cnt); end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_load_use();
      test_branch();
      test_multiply();
      test_flush_in_md();
      test_divide();
      test_back_to_back();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
